// File: rtl/layer_result_pingpong_mem_if.sv
// Producer/consumer bus of the ping-pong layer result store.
// master = the layers driving writes/reads, slave = the memory.
interface layer_result_pingpong_mem_if #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned ADDR_W = 16
);
    logic              save_enable;
    logic [ADDR_W-1:0] save_row_addr;
    logic [ADDR_W-1:0] save_col_addr;
    logic [DATA_W-1:0] store_data_in;
    logic              save_frame_done;
    logic              save_ready;
    logic              save_overflow;
    logic              read_signal;
    logic [ADDR_W-1:0] read_row_addr;
    logic [ADDR_W-1:0] read_col_addr;
    logic              read_frame_done;
    logic              read_avail;
    logic [DATA_W-1:0] result_output;
    logic              result_valid;

    modport master (
        output save_enable, save_row_addr, save_col_addr, store_data_in, save_frame_done,
        output read_signal, read_row_addr, read_col_addr, read_frame_done,
        input  save_ready, save_overflow, read_avail, result_output, result_valid
    );

    modport slave (
        input  save_enable, save_row_addr, save_col_addr, store_data_in, save_frame_done,
        input  read_signal, read_row_addr, read_col_addr, read_frame_done,
        output save_ready, save_overflow, read_avail, result_output, result_valid
    );
endinterface

// File: rtl/layer_result_pingpong_mem.sv
// Double-buffered ROWS x COLS result store; banks change owner on frame-done handshakes.
// Define LAYER_RESULT_MEM_OUTREG_EN for a registered (1-cycle) read port.
module layer_result_pingpong_mem #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned ROWS   = 5,
    parameter int unsigned COLS   = 5,
    parameter int unsigned ADDR_W = 16
) (
    input logic                         clk,
    input logic                         rst,
    layer_result_pingpong_mem_if.slave  bus
);
    localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [ADDR_W-1:0] RowsA = ADDR_W'(ROWS);
    localparam logic [ADDR_W-1:0] ColsA = ADDR_W'(COLS);

    logic [DATA_W-1:0] mem_q [2][ROWS][COLS];
    logic [1:0]        full_q, full_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic              overflow_q, overflow_d;

    logic              save_ready, read_avail;
    logic              wr_acc, save_fd_acc, read_fd_acc, rd_hit;
    logic [RowW-1:0]   wr_row, rd_row;
    logic [ColW-1:0]   wr_col, rd_col;
    logic [DATA_W-1:0] rd_data;

    assign save_ready = ~full_q[wr_bank_q];
    assign read_avail = full_q[rd_bank_q];

    // Full-width compare so aliased high address bits never hit the array.
    assign wr_acc = bus.save_enable && save_ready &&
                    (bus.save_row_addr < RowsA) && (bus.save_col_addr < ColsA);
    assign rd_hit = bus.read_signal && read_avail &&
                    (bus.read_row_addr < RowsA) && (bus.read_col_addr < ColsA);
    assign save_fd_acc = bus.save_frame_done && save_ready;
    assign read_fd_acc = bus.read_frame_done && read_avail;

    assign wr_row = bus.save_row_addr[RowW-1:0];
    assign wr_col = bus.save_col_addr[ColW-1:0];
    assign rd_row = bus.read_row_addr[RowW-1:0];
    assign rd_col = bus.read_col_addr[ColW-1:0];

    // Accepted frame-dones always target different banks, so both may apply.
    always_comb begin
        full_d     = full_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        overflow_d = overflow_q | ((bus.save_enable | bus.save_frame_done) & ~save_ready);
        if (save_fd_acc) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
        if (read_fd_acc) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q     <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < int'(ROWS); r++) begin
                    for (int c = 0; c < int'(COLS); c++) begin
                        mem_q[b][r][c] <= '0;
                    end
                end
            end
        end else if (wr_acc) begin
            mem_q[wr_bank_q][wr_row][wr_col] <= bus.store_data_in;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_hit) begin
            rd_data = mem_q[rd_bank_q][rd_row][rd_col];
        end
    end

`ifdef LAYER_RESULT_MEM_OUTREG_EN
    logic [DATA_W-1:0] result_q;
    logic              valid_q;

    // Sampled from the pre-swap bank, so a same-cycle read_frame_done is harmless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= rd_data;
            valid_q  <= rd_hit;
        end
    end

    assign bus.result_output = result_q;
    assign bus.result_valid  = valid_q;
`else
    assign bus.result_output = rd_data;
    assign bus.result_valid  = rd_hit;
`endif

    assign bus.save_ready    = save_ready;
    assign bus.read_avail    = read_avail;
    assign bus.save_overflow = overflow_q;
endmodule
